// File: rtl/wb_bus_arbiter.sv
// Round-robin arbiter for the 8:1 writeback mux with a bounded hold time per owner.
// Optional owner lock (suppresses hold-limit preemption) enabled by defining WB_ARB_LOCK_EN.
module wb_bus_arbiter #(
  parameter int NREQ     = 8,
  parameter int SEL_W    = 3,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef WB_ARB_LOCK_EN
  input  logic             lock,
`endif
  input  logic [NREQ-1:0]  req,
  output logic [NREQ-1:0]  gnt,
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  output logic [3:0]       hold_cnt_o
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

  state_t           state_r, state_s;
  logic [SEL_W-1:0] ptr_r, ptr_s;
  logic [NREQ-1:0]  gnt_r, gnt_s;
  logic [SEL_W-1:0] sel_r, sel_s;
  logic             busy_r, busy_s;
  logic [3:0]       hold_r, hold_s;

  logic [NREQ-1:0]  owner_mask_s;
  logic [NREQ-1:0]  others_s;
  logic             rel_a_s;
  logic             rel_b_s;
  logic             lock_s;
  logic [SEL_W:0]   win_idle_s;
  logic [SEL_W:0]   win_rel_s;

  // Returns {found, index} of the first set bit of r, scanning upward from p with wrap.
  function automatic logic [SEL_W:0] pick_winner(input logic [NREQ-1:0] r,
                                                 input logic [SEL_W-1:0] p);
    logic [SEL_W:0]   res;
    logic [SEL_W-1:0] idx;
    res = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = p + SEL_W'(i);
      if (r[idx]) begin
        res = {1'b1, idx};
      end
    end
    return res;
  endfunction

`ifdef WB_ARB_LOCK_EN
  assign lock_s = lock;
`else
  assign lock_s = 1'b0;
`endif

  // Release qualification for the current owner (sel_r holds the owner index).
  always_comb begin
    owner_mask_s = NREQ'(1) << sel_r;
    others_s     = req & ~owner_mask_s;
    rel_a_s      = ~|(req & owner_mask_s);
    rel_b_s      = (hold_r == HOLD_MAX) & (|others_s) & ~lock_s;
    win_idle_s   = pick_winner(req, ptr_r);
    win_rel_s    = pick_winner(others_s, sel_r + SEL_W'(1));
  end

  // Next-state and next-output logic.
  always_comb begin
    state_s = state_r;
    ptr_s   = ptr_r;
    gnt_s   = gnt_r;
    sel_s   = sel_r;
    busy_s  = busy_r;
    hold_s  = hold_r;
    case (state_r)
      ST_IDLE: begin
        if (win_idle_s[SEL_W]) begin
          state_s = ST_GRANT;
          gnt_s   = NREQ'(1) << win_idle_s[SEL_W-1:0];
          sel_s   = win_idle_s[SEL_W-1:0];
          busy_s  = 1'b1;
          hold_s  = 4'd1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (rel_a_s || rel_b_s) begin
          ptr_s = sel_r + SEL_W'(1);
          // Owner bit is already excluded from others_s, covering both release causes.
          if (win_rel_s[SEL_W]) begin
            state_s = ST_GRANT;
            gnt_s   = NREQ'(1) << win_rel_s[SEL_W-1:0];
            sel_s   = win_rel_s[SEL_W-1:0];
            busy_s  = 1'b1;
            hold_s  = 4'd1;
          end else begin
            state_s = ST_IDLE;
            gnt_s   = '0;
            busy_s  = 1'b0;
            hold_s  = 4'd0;
          end
        end else if (hold_r < HOLD_MAX) begin
          hold_s = hold_r + 4'd1;
        end else begin
          hold_s = hold_r;
        end
      end
      default: begin
        state_s = ST_IDLE;
        gnt_s   = '0;
        busy_s  = 1'b0;
        hold_s  = 4'd0;
      end
    endcase
  end

  // State, pointer and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      ptr_r   <= '0;
      gnt_r   <= '0;
      sel_r   <= '0;
      busy_r  <= 1'b0;
      hold_r  <= 4'd0;
    end else begin
      state_r <= state_s;
      ptr_r   <= ptr_s;
      gnt_r   <= gnt_s;
      sel_r   <= sel_s;
      busy_r  <= busy_s;
      hold_r  <= hold_s;
    end
  end

  assign gnt        = gnt_r;
  assign sel        = sel_r;
  assign busy       = busy_r;
  assign hold_cnt_o = hold_r;

endmodule

// File: doc/wb_bus_arbiter.md
Name: wb_bus_arbiter

Overview:
- Round-robin arbiter that shares the 32-bit 8:1 writeback/result mux between up to 8 requesters (ALU, shifter, load unit, branch link, HI/LO, etc.).
- Drives the mux's 3-bit select plus a one-hot grant back to the requesters.
- Sits between the execute-stage functional units and the register-file write port.
- Bounds bus ownership with a hold limit so no unit can starve the others.

Parameters:
- NREQ, 8, number of requesters; fixed to 8 to match the 3-bit mux select.
- SEL_W, 3, select width; must equal log2(NREQ).
- MAX_HOLD, 4, maximum consecutive cycles one owner keeps the bus while others are waiting; legal range 1..15.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  8  level request per requester; must stay high while the bus is wanted.
- gnt  output  8  one-hot grant, registered; all-zero when idle.
- sel  output  3  registered mux select, equal to the index of the granted requester.
- busy  output  1  high while any grant is active.
- hold_cnt_o  output  4  current ownership cycle count, for debug.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: gnt=0, sel=0, busy=0, hold_cnt=0, rr pointer=0, state=IDLE.
- FSM states: IDLE, GRANT.
- Winner function: first set bit of req, scanning from pointer upward with wrap 7->0.
- IDLE, req==0: stay in IDLE; outputs unchanged; sel keeps its last value.
- IDLE, req!=0: winner w latched at the edge. Next cycle: gnt=1<<w, sel=w, busy=1, hold_cnt=1, state=GRANT.
- Latency: 1 cycle from req seen to gnt.
- GRANT, owner k, release conditions:
  - (a) req[k]==0, or
  - (b) hold_cnt==MAX_HOLD and (req & ~(1<<k))!=0.
- GRANT, no release: hold_cnt increments, saturating at MAX_HOLD. With no other requester, the owner keeps the bus indefinitely.
- On release:
  - pointer = (k+1) mod 8.
  - Winner recomputed from the new pointer over the current req, with bit k masked for case (b).
  - If a winner exists: handoff in the same edge, with no idle bubble; gnt/sel switch directly and hold_cnt=1.
  - Otherwise: state=IDLE, gnt=0, busy=0, hold_cnt=0; sel holds its value.
- gnt is always one-hot or zero; sel never changes while a grant is held.
- Requests arriving mid-grant are only considered at release.
- Pointer wrap: owner 7 releasing sets pointer=0.
- Reset asserted mid-grant: outputs immediately go to reset values, with no wait for the clock; the pointer returns to 0.

Optional Feature:
- Macro: WB_ARB_LOCK_EN.
- With the macro: extra input port lock (1 bit).
  - While the current owner has lock=1, release condition (b) is suppressed and hold_cnt saturates.
  - The owner keeps the bus until req[k] drops. Used for atomic HI/LO double writes.
  - lock is ignored in IDLE.
- Without the macro: no lock port; MAX_HOLD preemption always applies.

Test Plan:
- Reset then req=8'h00 for 5 cycles -> gnt=0, busy=0, sel=0 throughout; async rst_n low mid-cycle clears gnt with no clock edge.
- req=8'h01 held 3 cycles then dropped -> gnt=8'h01 one cycle after req, busy 3 cycles, then IDLE; next req=8'h03 grants bit1 first (pointer=1).
- req=8'h81 held continuously, MAX_HOLD=4 -> gnt alternates 8'h01 (4 cycles), 8'h80 (4 cycles), 8'h01 ..., no idle bubble between owners.
- Owner 2 holds with req=8'h04 for 10 cycles, no other req -> gnt stays 8'h04 all 10 cycles, hold_cnt_o saturates at 4.
- Owner 7 drops while req=8'h11 -> next grant bit0 (pointer wrapped to 0), sel=0, in the same edge.
- With WB_ARB_LOCK_EN: owner 3 lock=1, req=8'h09 for 8 cycles -> gnt stays 8'h08 for all 8; lock drops at cycle 9 -> gnt=8'h01 the next edge.
